// File: rtl/load_pkg.sv
// Shared types and helpers for the streaming vector loader.
package load_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } load_state_e;

  function automatic int calc_lanes(input int mem_w, input int data_w);
    return mem_w / data_w;
  endfunction

  function automatic int calc_elem_count(input int tile_w, input int data_w);
    return tile_w / data_w;
  endfunction

  // Bit offset of a lane inside a memory beat; lane 0 holds the lowest address.
  function automatic int lane_lsb(input int lane, input int data_w);
    return lane * data_w;
  endfunction

endpackage

// File: rtl/tile_out_reg.sv
// One-entry valid/ready register holding the tile presented to the compute datapath.
module tile_out_reg #(
  parameter int ELEM_COUNT = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  load,
  input  logic [ELEM_COUNT-1:0][DATA_WIDTH-1:0] load_data,
  input  logic                                  load_last,
  input  logic                                  ready,
  output logic                                  valid,
  output logic [ELEM_COUNT-1:0][DATA_WIDTH-1:0] data,
  output logic                                  last
);

  // load is only raised when the register is empty or being accepted,
  // so data/last never change under valid && !ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/load_v_stream.sv
// Streaming vector loader: reads contiguous elements in wide beats, packs them
// into zero-padded tiles and hands tiles out over valid/ready.
// Handshake: a tile transfers in any cycle where tile_valid && tile_ready;
// while tile_valid && !tile_ready, tile_data and tile_last hold steady.
module load_v_stream
  import load_pkg::*;
#(
  parameter int TILE_WIDTH      = 256,
  parameter int DATA_WIDTH      = 8,
  parameter int MEM_WIDTH       = 32,
  parameter int ADDR_WIDTH      = 24,
  parameter int LEN_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 2,
  localparam int ELEM_COUNT     = calc_elem_count(TILE_WIDTH, DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] dram_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] tile_data [ELEM_COUNT],
  output logic                  tile_valid,
  output logic                  tile_last,
  input  logic                  tile_ready,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [MEM_WIDTH-1:0]  mem_rdata,
  input  logic                  mem_valid,
  output load_state_e           fsm_state
);

  localparam int LANES     = calc_lanes(MEM_WIDTH, DATA_WIDTH);
  localparam int BPT       = ELEM_COUNT / LANES;
  localparam int LANE_BITS = $clog2(LANES);
  localparam int CW        = LEN_WIDTH + 1;
  localparam int EW        = LEN_WIDTH + 2;
  localparam int SW        = $clog2(BPT + MAX_OUTSTANDING + 1);

  typedef logic [ELEM_COUNT-1:0][DATA_WIDTH-1:0] tile_t;

  load_state_e           state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [EW-1:0]         len_q;
  logic [EW-1:0]         elem_base;
  logic [CW-1:0]         total_beats, total_tiles;
  logic [CW-1:0]         beats_issued, beats_captured, tile_idx;
  logic [SW-1:0]         fill, outstanding;
  logic                  done_q;
  tile_t                 asm_buf, asm_merged, asm_data, out_data;
  logic                  asm_full, cap, cap_done, asm_ready;
  logic                  can_load, handoff, load_last, flush_clear, issue;
  logic                  out_valid, out_last;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = (length != '0) ? ST_FETCH : ST_DONE;
      end
      ST_FETCH: begin
        // Never request more beats than the current tile can still absorb.
        issue = (beats_issued < total_beats) &&
                (outstanding < SW'(MAX_OUTSTANDING)) &&
                ((fill + outstanding) < SW'(BPT));
        if (beats_issued == total_beats) state_nx = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_clear) state_nx = ST_DONE;
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // ---------------- assembly / handoff ----------------
  assign cap = mem_valid && (outstanding != '0) &&
               ((state == ST_FETCH) || (state == ST_FLUSH));

  always_comb begin
    asm_merged = asm_buf;
    for (int s = 0; s < BPT; s++) begin
      if (fill == SW'(s)) begin
        for (int l = 0; l < LANES; l++) begin
          if ((elem_base + EW'(l)) < len_q)
            asm_merged[s*LANES + l] = mem_rdata[lane_lsb(l, DATA_WIDTH) +: DATA_WIDTH];
          else
            asm_merged[s*LANES + l] = '0;
        end
      end
    end
  end

  assign cap_done    = cap && ((fill == SW'(BPT - 1)) ||
                               (beats_captured == total_beats - CW'(1)));
  assign asm_ready   = asm_full || cap_done;
  assign asm_data    = asm_full ? asm_buf : asm_merged;
  assign can_load    = !out_valid || tile_ready;
  assign handoff     = asm_ready && can_load;
  assign load_last   = (tile_idx == total_tiles - CW'(1));
  assign flush_clear = (outstanding == '0) && !asm_full && (!out_valid || tile_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q         <= '0;
      len_q          <= '0;
      elem_base      <= '0;
      total_beats    <= '0;
      total_tiles    <= '0;
      beats_issued   <= '0;
      beats_captured <= '0;
      tile_idx       <= '0;
      fill           <= '0;
      outstanding    <= '0;
      asm_buf        <= '0;
      asm_full       <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q <= (state == ST_DONE);
      if ((state == ST_IDLE) && start) begin
        addr_q         <= dram_addr & ~ADDR_WIDTH'(LANES - 1);
        len_q          <= EW'(length);
        total_beats    <= ({1'b0, length} + CW'(LANES - 1)) >> LANE_BITS;
        total_tiles    <= ({1'b0, length} + CW'(ELEM_COUNT - 1)) / CW'(ELEM_COUNT);
        elem_base      <= '0;
        beats_issued   <= '0;
        beats_captured <= '0;
        tile_idx       <= '0;
        fill           <= '0;
        outstanding    <= '0;
        asm_buf        <= '0;
        asm_full       <= 1'b0;
      end else begin
        if (issue) begin
          addr_q       <= addr_q + ADDR_WIDTH'(LANES);
          beats_issued <= beats_issued + CW'(1);
        end
        case ({issue, cap})
          2'b10:   outstanding <= outstanding + SW'(1);
          2'b01:   outstanding <= outstanding - SW'(1);
          default: outstanding <= outstanding;
        endcase
        if (cap) begin
          beats_captured <= beats_captured + CW'(1);
          elem_base      <= elem_base + EW'(LANES);
        end
        // A completed tile may bypass the buffer straight into the output register.
        if (handoff) begin
          asm_buf  <= '0;
          fill     <= '0;
          asm_full <= 1'b0;
          tile_idx <= tile_idx + CW'(1);
        end else if (cap) begin
          asm_buf  <= asm_merged;
          fill     <= fill + SW'(1);
          asm_full <= cap_done;
        end
      end
    end
  end

  tile_out_reg #(
    .ELEM_COUNT (ELEM_COUNT),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (handoff),
    .load_data (asm_data),
    .load_last (load_last),
    .ready     (tile_ready),
    .valid     (out_valid),
    .data      (out_data),
    .last      (out_last)
  );

  for (genvar i = 0; i < ELEM_COUNT; i++) begin : g_tile
    assign tile_data[i] = out_data[i];
  end

  assign tile_valid = out_valid;
  assign tile_last  = out_last;
  assign mem_req    = issue;
  assign mem_addr   = addr_q;
  assign busy       = (state != ST_IDLE);
  assign done       = done_q;
  assign fsm_state  = state;

endmodule

// File: doc/load_v_stream.md
# load_v_stream

Streaming vector loader: fetches `length` contiguous elements from DRAM over a multi-element memory bus and packs them into TILE_WIDTH-bit tiles. Each tile is handed to the compute datapath over a valid/ready handshake, and elements past `length` in the final tile are zero-padded. It sits between the memory arbiter and the vector/tile buffers. It generalises the single-byte, fixed-latency, no-backpressure vector load with these additions:

- wide memory beats
- variable memory latency with bounded outstanding reads
- tile backpressure
- last-tile marking

## Interface
Parameters:
- TILE_WIDTH, 256, bits per output tile
- DATA_WIDTH, 8, bits per element
- MEM_WIDTH, 32, memory read-data width; LANES = MEM_WIDTH/DATA_WIDTH elements per beat
- ADDR_WIDTH, 24, element-address width
- LEN_WIDTH, 16, length field width (elements)
- MAX_OUTSTANDING, 2, maximum issued-but-unreturned reads (≥1)
- Legality: ELEM_COUNT = TILE_WIDTH/DATA_WIDTH must be a multiple of LANES. LANES must be a power of two.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  command strobe; accepted only when busy=0
- dram_addr  in  ADDR_WIDTH  first element address. Low log2(LANES) bits are treated as zero.
- length  in  LEN_WIDTH  element count; sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at command completion
- tile_data  out  ELEM_COUNT×DATA_WIDTH (unpacked array)  output tile; element 0 = lowest address
- tile_valid  out  1  tile_data valid
- tile_last  out  1  qualifies tile_valid; final tile of command
- tile_ready  in  1  consumer accepts tile
- mem_req  out  1  read request; one beat per asserted cycle
- mem_addr  out  ADDR_WIDTH  beat address; valid with mem_req
- mem_rdata  in  MEM_WIDTH  beat data. Lane i is bits [i*DATA_WIDTH +: DATA_WIDTH] and holds element at mem_addr+i.
- mem_valid  in  1  one response per request, in order, latency ≥1 cycle

## Operation
- Derived counts:
  - total_beats = ceil(length/LANES)
  - total_tiles = ceil(length/ELEM_COUNT)
  - beats_per_tile = ELEM_COUNT/LANES
  - Internal counters are LEN_WIDTH+1 bits wide; no truncation at max length.
- FSM states are IDLE, FETCH, FLUSH, DONE:
  - IDLE: on start, latch the address and length. Go to FETCH if length≠0, else DONE.
  - FETCH: mem_req=1 iff all of:
    - beats_issued < total_beats
    - outstanding < MAX_OUTSTANDING
    - (beats captured + outstanding) in current tile < beats_per_tile
  - FETCH, on each issued request: mem_addr advances by LANES.
  - FETCH, on each mem_valid: write the beat into the assembly buffer at beat slot.
  - FETCH → FLUSH when beats_issued == total_beats.
  - FLUSH: wait until outstanding == 0, the assembly buffer is handed off, and the output register is drained. Then go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
- Assembly buffer completes when its beat slot count reaches beats_per_tile, or when the last beat of the command is captured.
  - Lanes/elements with global index ≥ length are written 0. This includes unfilled slots of the last tile.
  - Padding never issues a memory read.
- Handoff: a complete assembly buffer moves to the output register when the register is empty or is being accepted (tile_valid&&tile_ready) in the same cycle.
  - The assembly buffer is cleared on handoff.
  - tile_last is set when the handoff carries tile index total_tiles-1.
- tile_data and tile_last are held stable while tile_valid&&!tile_ready.
- start while busy is ignored.
- mem_valid in IDLE or DONE is ignored.

## Timing
- Reset values: busy=0, done=0, tile_valid=0, tile_last=0, mem_req=0, mem_addr=0, tile_data all 0. FSM=IDLE; counters, outstanding count and buffers are 0.
- start at cycle T → first mem_req at T+1 with mem_addr = aligned dram_addr.
- 1-cycle memory with tile_ready=1: one beat per cycle, with these consequences:
  - Tile k's last beat is captured at cycle C; tile_valid rises at C+1.
  - The next tile's first request is issued at C+1.
  - done pulses 2 cycles after the final tile is accepted.
- length=0: done at T+2, no mem_req, no tile.
- Same-cycle mem_valid and issue: outstanding is unchanged.
- Reset mid-command: all state is abandoned immediately; no done pulse.

## Structure
- Package `load_pkg`: FSM state enum, ELEM_COUNT/LANES helper functions, and the lane-slice function.
- Sub-module `tile_out_reg`: one-entry valid/ready output register holding tile_data/tile_last.
- The FSM and assembly buffer live in the top module.

## Test plan
All scenarios use the default parameters (ELEM_COUNT=32, LANES=4).
- length=32, addr=0x100, 1-cycle memory, ready=1 → 8 requests at 0x100..0x11C step 4, consecutive cycles. One tile with tile_last=1 equal to memory bytes. done once.
- length=37, addr=0x200 → 10 requests and two tiles. Tile 1 elements 0..4 = memory 0x220..0x224, elements 5..31 = 0. tile_last only on tile 1. Lanes 1..3 of beat 0x224 are zeroed.
- length=0 → done at T+2; mem_req and tile_valid never assert.
- length=96, tile_ready low for 30 cycles after the first tile_valid → fetch stalls with tiles 0 and 1 buffered. tile_data is stable while stalled. All 3 tiles are later delivered in order and bit-exact.
- Memory latency 3, MAX_OUTSTANDING=2, length=64 → outstanding never exceeds 2. Data is correct. 16 requests total.
- rst asserted mid-FETCH at length=64 → all outputs at reset values that cycle, no done. A later start with length=32 completes correctly.
